// File: rtl/nibble_serial_subtractor.sv
// Serial two's-complement subtractor: a - b computed one nibble per cycle with 4-bit carry lookahead.
// Build macro SUB_SATURATE_EN clamps d to the signed range when the subtraction overflows.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // RUN   | adding one nibble of a, ~b per cycle, LS nibble first
    // DONE  | result presented with out_valid=1 until out_ready
    localparam int NIB = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, bn_q, d_q, d_next, d_fin;
    logic             carry_q, borrow_q, ovf_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW+1:0]  sh;
    logic [3:0]       an, bn, g, p, c, sum;
    logic             cout, last, ovf_next;

    assign last = (idx_q == LAST_IDX);
    assign sh   = {idx_q, 2'b00};

    always_comb begin
        an  = 4'(a_q >> sh);
        bn  = 4'(bn_q >> sh);
        g   = an & bn;
        p   = an ^ bn;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & c[0]);
        sum  = p ^ c;
        d_next = (d_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(sum) << sh);
        // a and b differ in sign exactly when a and ~b share a sign bit
        ovf_next = (a_q[WIDTH-1] == bn_q[WIDTH-1]) && (sum[3] != a_q[WIDTH-1]);
    end

`ifdef SUB_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        d_fin = d_next;
        if (ovf_next) d_fin = a_q[WIDTH-1] ? MIN_NEG : MAX_POS;
    end
`else
    assign d_fin = d_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            bn_q     <= '0;
            d_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        bn_q    <= ~b;
                        carry_q <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    d_q     <= last ? d_fin : d_next;
                    carry_q <= cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        borrow_q <= ~cout;
                        ovf_q    <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign d      = d_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits, a multiple of 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: minuend a and subtrahend b, two's complement.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port d, output, WIDTH bits: the difference a - b.
REQ-010 The block SHALL have port borrow, output, 1 bit: unsigned borrow, 1 when a < b unsigned.
REQ-011 The block SHALL have port ovf, output, 1 bit: signed overflow of a - b.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
- IDLE: in_ready=1 and out_valid=0.
- RUN: in_ready=0 and out_valid=0.
- DONE: in_ready=0 and out_valid=1.
REQ-013 In IDLE, when in_valid=1 at a rising edge, the block SHALL:
- register a and ~b;
- set carry to 1 and nibble index to 0;
- move to RUN.
REQ-014 Each RUN cycle SHALL add one nibble of a, ~b and carry, least-significant nibble first.
- Carries SHALL use a 4-bit group lookahead: per-bit g=a&~b, p=a^~b, sum=p^c.
- The result nibble SHALL be written into d.
- Carry SHALL become the group carry-out.
- The nibble index SHALL increment.
REQ-015 After WIDTH/4 RUN cycles the FSM SHALL enter DONE.
- Latency from the accept edge to out_valid rising SHALL be WIDTH/4 edges (4 for WIDTH=16).
REQ-016 In DONE, d, borrow and ovf SHALL hold stable until out_ready=1 at a rising edge; the FSM then SHALL return to IDLE.
REQ-017 borrow SHALL equal the inverse of the final carry-out.
REQ-018 ovf SHALL equal (a[MSB] != b[MSB]) && (raw d[MSB] != a[MSB]), computed from the registered operands.
REQ-019 in_valid seen in RUN or DONE SHALL be ignored; operands are not captured.
- Back-to-back accept in the DONE->IDLE cycle SHALL NOT occur.
- Minimum spacing between accepts SHALL be WIDTH/4+2 cycles.
REQ-020 Changes on a/b after the accept edge SHALL NOT affect the result.
REQ-021 d SHALL hold the last value outside DONE; only out_valid qualifies it.

Reset
REQ-022 When rst_n=0 the block SHALL asynchronously enter IDLE and clear internal operand, carry and index registers.
- d=0, borrow=0, ovf=0, out_valid=0, in_ready=1.
REQ-023 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no result delivered.
REQ-024 The first accept after release SHALL be allowed on the first rising edge with rst_n=1.

Configuration
REQ-025 With macro SUB_SATURATE_EN defined, when ovf=1 in DONE, d SHALL be clamped.
- a[MSB]=0 clamps to the maximum positive value (0x7FFF).
- a[MSB]=1 clamps to the minimum negative value (0x8000).
- ovf and borrow SHALL be unchanged.
REQ-026 Without SUB_SATURATE_EN, d SHALL be the wrapped difference modulo 2^WIDTH; the clamp logic SHALL be absent.

Verification (WIDTH=16)
REQ-027 a=0x0005, b=0x0003, in_valid for 1 cycle -> out_valid 4 edges after accept, d=0x0002, borrow=0, ovf=0.
REQ-028 a=0x0000, b=0x0001 -> d=0xFFFF, borrow=1, ovf=0.
REQ-029 a=0x8000, b=0x0001 -> ovf=1, borrow=0; d=0x7FFF without the macro, d=0x8000 with SUB_SATURATE_EN.
REQ-030 a=0x7FFF, b=0xFFFF -> ovf=1, borrow=1; d=0x8000 without the macro, d=0x7FFF with SUB_SATURATE_EN.
REQ-031 a=0x1234, b=0x0234, out_ready held low 3 cycles in DONE -> d=0x1000 stable, in_ready=0, new in_valid ignored; IDLE one edge after out_ready=1.
REQ-032 rst_n pulsed low during the 2nd RUN cycle -> immediately out_valid=0, d=0, in_ready=1; no result is ever presented for that operation.
